wb_merge: RTL and testbench

//  Writeback end of the execute datapath. Consumes ALU-stage results (exec1) and

---
 rtl/wb_merge_if.sv | 47 ++++
 rtl/wb_merge.sv | 175 +++++++++++++++++
 tb/tb_wb_merge.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/wb_merge_if.sv
// Writeback-merge bus: ALU/mul result inputs, forwarding lookup, register-file write port.
// Optional trap outputs exc_valid/exc_reg exist only when OVF_TRAP_EN is defined.
interface wb_merge_if #(
  parameter int REG_SIZE = 32,
  parameter int REG_ADDR = 5
);
  logic                alu_regwrite;
  logic [REG_ADDR-1:0] alu_wreg;
  logic [REG_SIZE-1:0] alu_result;
  logic                alu_overflow;
  logic                mul_regwrite;
  logic [REG_ADDR-1:0] mul_wreg;
  logic [REG_SIZE-1:0] mul_result;
  logic                mul_overflow;
  logic [REG_ADDR-1:0] lookup_reg;
  logic                lookup_hit;
  logic [REG_SIZE-1:0] lookup_data;
  logic                rf_we;
  logic [REG_ADDR-1:0] rf_waddr;
  logic [REG_SIZE-1:0] rf_wdata;
  logic                alu_stall;
  logic                err_drop;
`ifdef OVF_TRAP_EN
  logic                exc_valid;
  logic [REG_ADDR-1:0] exc_reg;
`endif

  modport master (
    output alu_regwrite, alu_wreg, alu_result, alu_overflow,
    output mul_regwrite, mul_wreg, mul_result, mul_overflow,
    output lookup_reg,
    input  lookup_hit, lookup_data, rf_we, rf_waddr, rf_wdata, alu_stall, err_drop
`ifdef OVF_TRAP_EN
    , input exc_valid, exc_reg
`endif
  );

  modport slave (
    input  alu_regwrite, alu_wreg, alu_result, alu_overflow,
    input  mul_regwrite, mul_wreg, mul_result, mul_overflow,
    input  lookup_reg,
    output lookup_hit, lookup_data, rf_we, rf_waddr, rf_wdata, alu_stall, err_drop
`ifdef OVF_TRAP_EN
    , output exc_valid, exc_reg
`endif
  );
endinterface

// File: rtl/wb_merge.sv
// Writeback merge: mul results always win the register-file port, ALU results queue in an
// in-order FIFO behind them. Optional overflow trapping is enabled with OVF_TRAP_EN.
module wb_merge #(
  parameter int REG_SIZE  = 32,
  parameter int REG_ADDR  = 5,
  parameter int BUF_DEPTH = 2
) (
  input logic       clk,
  input logic       reset,
  wb_merge_if.slave bus
);
  localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CNT_W = $clog2(BUF_DEPTH + 1);

  typedef enum logic [1:0] {EMPTY, PARTIAL, FULL} state_e;

  state_e              state_q, state_d;
  logic [REG_ADDR-1:0] buf_wreg_q [BUF_DEPTH];
  logic [REG_SIZE-1:0] buf_data_q [BUF_DEPTH];
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                rf_we_q, rf_we_d;
  logic [REG_ADDR-1:0] rf_waddr_q, rf_waddr_d;
  logic [REG_SIZE-1:0] rf_wdata_q, rf_wdata_d;
  logic                alu_stall_q, alu_stall_d;
  logic                err_drop_q, err_drop_d;
  logic                alu_req, mul_req, push, pop;
  logic                fifo_hit;
  logic [REG_SIZE-1:0] fifo_data;
  int                  idx;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

`ifdef OVF_TRAP_EN
  logic                mul_trap, alu_trap;
  logic                exc_valid_q, exc_valid_d;
  logic [REG_ADDR-1:0] exc_reg_q, exc_reg_d;

  // An overflowing request is diverted to the trap outputs instead of the write path.
  assign mul_trap = bus.mul_regwrite && (|bus.mul_wreg) && bus.mul_overflow;
  assign alu_trap = bus.alu_regwrite && (|bus.alu_wreg) && bus.alu_overflow;
  assign mul_req  = bus.mul_regwrite && (|bus.mul_wreg) && !bus.mul_overflow;
  assign alu_req  = bus.alu_regwrite && (|bus.alu_wreg) && !bus.alu_overflow;
  assign bus.exc_valid = exc_valid_q;
  assign bus.exc_reg   = exc_reg_q;
`else
  logic unused_ovf;
  assign unused_ovf = bus.mul_overflow ^ bus.alu_overflow;
  assign mul_req    = bus.mul_regwrite && (|bus.mul_wreg);
  assign alu_req    = bus.alu_regwrite && (|bus.alu_wreg);
`endif

  always_comb begin
    push       = 1'b0;
    pop        = 1'b0;
    rf_we_d    = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    err_drop_d = err_drop_q;
    if (mul_req) begin
      rf_we_d    = 1'b1;
      rf_waddr_d = bus.mul_wreg;
      rf_wdata_d = bus.mul_result;
      if (alu_req) begin
        if (state_q != FULL) push = 1'b1;
        else                 err_drop_d = 1'b1;
      end
    end else if (state_q != EMPTY) begin
      // Head drains first; a full FIFO can still accept the ALU result as the head leaves.
      pop        = 1'b1;
      push       = alu_req;
      rf_we_d    = 1'b1;
      rf_waddr_d = buf_wreg_q[rd_ptr_q];
      rf_wdata_d = buf_data_q[rd_ptr_q];
    end else if (alu_req) begin
      rf_we_d    = 1'b1;
      rf_waddr_d = bus.alu_wreg;
      rf_wdata_d = bus.alu_result;
    end
`ifdef OVF_TRAP_EN
    exc_valid_d = mul_trap || alu_trap;
    exc_reg_d   = mul_trap ? bus.mul_wreg : (alu_trap ? bus.alu_wreg : '0);
    if (mul_trap && alu_trap) err_drop_d = 1'b1;
`endif
    count_d = count_q;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;
    rd_ptr_d    = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    wr_ptr_d    = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    alu_stall_d = (count_d >= CNT_W'(BUF_DEPTH - 1));
    if (count_d == '0)                        state_d = EMPTY;
    else if (count_d == CNT_W'(BUF_DEPTH))    state_d = FULL;
    else                                      state_d = PARTIAL;
  end

  // Forwarding: mul input, youngest FIFO entry, ALU input, then the registered write.
  always_comb begin
    fifo_hit  = 1'b0;
    fifo_data = '0;
    idx       = 0;
    for (int i = 0; i < BUF_DEPTH; i++) begin
      idx = int'(rd_ptr_q) + i;
      if (idx >= BUF_DEPTH) idx = idx - BUF_DEPTH;
      if (i < int'(count_q) && buf_wreg_q[idx[PTR_W-1:0]] == bus.lookup_reg) begin
        fifo_hit  = 1'b1;
        fifo_data = buf_data_q[idx[PTR_W-1:0]];
      end
    end
    bus.lookup_hit  = 1'b0;
    bus.lookup_data = '0;
    if (bus.lookup_reg != '0) begin
      if (mul_req && bus.mul_wreg == bus.lookup_reg) begin
        bus.lookup_hit  = 1'b1;
        bus.lookup_data = bus.mul_result;
      end else if (fifo_hit) begin
        bus.lookup_hit  = 1'b1;
        bus.lookup_data = fifo_data;
      end else if (alu_req && bus.alu_wreg == bus.lookup_reg) begin
        bus.lookup_hit  = 1'b1;
        bus.lookup_data = bus.alu_result;
      end else if (rf_we_q && rf_waddr_q == bus.lookup_reg) begin
        bus.lookup_hit  = 1'b1;
        bus.lookup_data = rf_wdata_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= EMPTY;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      rf_we_q     <= 1'b0;
      rf_waddr_q  <= '0;
      rf_wdata_q  <= '0;
      alu_stall_q <= 1'b0;
      err_drop_q  <= 1'b0;
`ifdef OVF_TRAP_EN
      exc_valid_q <= 1'b0;
      exc_reg_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      rf_we_q     <= rf_we_d;
      rf_waddr_q  <= rf_waddr_d;
      rf_wdata_q  <= rf_wdata_d;
      alu_stall_q <= alu_stall_d;
      err_drop_q  <= err_drop_d;
`ifdef OVF_TRAP_EN
      exc_valid_q <= exc_valid_d;
      exc_reg_q   <= exc_reg_d;
`endif
    end
  end

  // FIFO payload needs no reset; occupancy is governed by count_q.
  always_ff @(posedge clk) begin
    if (push) begin
      buf_wreg_q[wr_ptr_q] <= bus.alu_wreg;
      buf_data_q[wr_ptr_q] <= bus.alu_result;
    end
  end

  assign bus.rf_we     = rf_we_q;
  assign bus.rf_waddr  = rf_waddr_q;
  assign bus.rf_wdata  = rf_wdata_q;
  assign bus.alu_stall = alu_stall_q;
  assign bus.err_drop  = err_drop_q;
endmodule

// File: tb/tb_wb_merge.sv
// Randomized scoreboard bench for wb_merge; the model keeps pending ALU results in a queue
// and predicts each register-file write, stall, sticky drop flag and forwarding answer.
module tb_wb_merge;
  localparam int DEPTH = 2;

  typedef struct {
    logic [4:0]  r;
    logic [31:0] d;
  } ent_t;

  typedef struct {
    int          cyc;
    logic [4:0]  r;
    logic [31:0] d;
  } sb_t;

  logic clk;
  logic reset;
  int   cyc;
  int   checks;
  int   failures;
  bit   running;

  ent_t fifo_m[$];
  sb_t  sbq[$];
  sb_t  mon_e;
  logic        exp_stall, exp_err, last_we;
  logic [4:0]  last_addr;
  logic [31:0] last_data;
  logic        exp_exc_v;
  logic [4:0]  exp_exc_r;

  wb_merge_if #(.REG_SIZE(32), .REG_ADDR(5)) bus ();

  wb_merge #(.REG_SIZE(32), .REG_ADDR(5), .BUF_DEPTH(DEPTH)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every cycle the registered write port is compared with the scoreboard head.
  always @(negedge clk) begin
    if (running) begin
      if (sbq.size() > 0 && sbq[0].cyc == cyc) begin
        mon_e = sbq.pop_front();
        chk("rf_we", 32'(bus.rf_we), 32'd1);
        chk("rf_waddr", 32'(bus.rf_waddr), 32'(mon_e.r));
        chk("rf_wdata", bus.rf_wdata, mon_e.d);
      end else begin
        chk("rf_we_idle", 32'(bus.rf_we), 32'd0);
      end
    end
  end

  task automatic model_clear();
    fifo_m.delete();
    exp_stall = 1'b0;
    exp_err   = 1'b0;
    last_we   = 1'b0;
    last_addr = '0;
    last_data = '0;
    exp_exc_v = 1'b0;
    exp_exc_r = '0;
  endtask

  task automatic drive(input logic mr, input logic [4:0] mw, input logic [31:0] md, input logic mo,
                       input logic ar, input logic [4:0] aw, input logic [31:0] ad, input logic ao,
                       input logic [4:0] lk);
    bus.mul_regwrite = mr; bus.mul_wreg = mw; bus.mul_result = md; bus.mul_overflow = mo;
    bus.alu_regwrite = ar; bus.alu_wreg = aw; bus.alu_result = ad; bus.alu_overflow = ao;
    bus.lookup_reg   = lk;
  endtask

  task automatic step(input logic mr, input logic [4:0] mw, input logic [31:0] md, input logic mo,
                      input logic ar, input logic [4:0] aw, input logic [31:0] ad, input logic ao,
                      input logic [4:0] lk);
    logic        mreq, areq, exp_hit, wr;
    logic [31:0] exp_ld;
    ent_t        w;
    @(posedge clk);
    #1;
    chk("alu_stall", 32'(bus.alu_stall), 32'(exp_stall));
    chk("err_drop", 32'(bus.err_drop), 32'(exp_err));
`ifdef OVF_TRAP_EN
    chk("exc_valid", 32'(bus.exc_valid), 32'(exp_exc_v));
    if (exp_exc_v) chk("exc_reg", 32'(bus.exc_reg), 32'(exp_exc_r));
`endif
    drive(mr, mw, md, mo, ar, aw, ad, ao, lk);
    mreq = mr && (mw != 0);
    areq = ar && (aw != 0);
`ifdef OVF_TRAP_EN
    exp_exc_v = (mreq && mo) || (areq && ao);
    exp_exc_r = (mreq && mo) ? mw : ((areq && ao) ? aw : 5'd0);
    if (mreq && mo && areq && ao) exp_err = 1'b1;
    mreq = mreq && !mo;
    areq = areq && !ao;
`endif
    exp_hit = 1'b0;
    exp_ld  = '0;
    if (lk != 0) begin
      if (mreq && mw == lk) begin
        exp_hit = 1'b1; exp_ld = md;
      end else begin
        for (int i = fifo_m.size() - 1; i >= 0 && !exp_hit; i--)
          if (fifo_m[i].r == lk) begin exp_hit = 1'b1; exp_ld = fifo_m[i].d; end
        if (!exp_hit && areq && aw == lk) begin exp_hit = 1'b1; exp_ld = ad; end
        if (!exp_hit && last_we && last_addr == lk) begin exp_hit = 1'b1; exp_ld = last_data; end
      end
    end
    #1;
    chk("lookup_hit", 32'(bus.lookup_hit), 32'(exp_hit));
    chk("lookup_data", bus.lookup_data, exp_ld);
    wr = 1'b0;
    w  = '{r: 5'd0, d: 32'd0};
    if (mreq) begin
      wr = 1'b1; w = '{r: mw, d: md};
      if (areq) begin
        if (fifo_m.size() < DEPTH) fifo_m.push_back('{r: aw, d: ad});
        else exp_err = 1'b1;
      end
    end else if (fifo_m.size() > 0) begin
      wr = 1'b1; w = fifo_m.pop_front();
      if (areq) fifo_m.push_back('{r: aw, d: ad});
    end else if (areq) begin
      wr = 1'b1; w = '{r: aw, d: ad};
    end
    if (wr) sbq.push_back('{cyc: cyc + 1, r: w.r, d: w.d});
    last_we = wr;
    if (wr) begin last_addr = w.r; last_data = w.d; end
    exp_stall = (fifo_m.size() >= DEPTH - 1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Holds reset for n cycles with both request paths active.
  task automatic do_reset(input int n);
    @(posedge clk);
    #1;
    reset = 1'b1;
    drive(1, 5'd5, 32'hAA, 0, 1, 5'd6, 32'hBB, 0, 5'd0);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      chk("rst_stall", 32'(bus.alu_stall), 32'd0);
      chk("rst_err", 32'(bus.err_drop), 32'd0);
      chk("rst_we", 32'(bus.rf_we), 32'd0);
    end
    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    model_clear();
  endtask

  initial begin
    logic ar, obey;
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    running  = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    model_clear();
    repeat (2) @(posedge clk);
    running = 1'b1;
    do_reset(2);

    step(0, 0, 0, 0, 1, 5'd3, 32'h1234, 0, 5'd0);
    idle(2);

    step(1, 5'd5, 32'hAA, 0, 1, 5'd6, 32'hBB, 0, 5'd0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 5'd6);
    idle(2);

    for (int i = 0; i < 4; i++)
      step(1, 5'(8 + i), 32'(i), 0, 1, 5'(i + 1), 32'h100 + 32'(i), 0, 5'd0);
    idle(3);
    chk("burst_err_sticky", 32'(bus.err_drop), 32'd1);

    step(0, 0, 0, 0, 1, 5'd0, 32'hDEAD, 0, 5'd0);
    idle(2);

`ifdef OVF_TRAP_EN
    step(0, 0, 0, 0, 1, 5'd7, 32'h77, 1, 5'd7);
    idle(2);
    step(1, 5'd9, 32'h99, 1, 1, 5'd10, 32'h10, 1, 5'd0);
    idle(2);
`endif

    do_reset(1);
    for (int n = 0; n < 500; n++) begin
      obey = ($urandom_range(0, 9) < 8);
      ar   = 1'($urandom_range(0, 2) != 0);
      if (obey && exp_stall) ar = 1'b0;
      step(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom, 1'($urandom_range(0, 5) == 0),
           ar, 5'($urandom_range(0, 7)), $urandom, 1'($urandom_range(0, 5) == 0),
           5'($urandom_range(0, 7)));
      if (n == 250) do_reset(1);
    end
    idle(DEPTH + 3);
    running = 1'b0;
    chk("scoreboard_drained", 32'(sbq.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
